// File: rtl/spio_spinnaker_link_pkg.sv
// Shared types and helpers for the SpiNNaker link transmit path.
package spio_spinnaker_link_pkg;

    // Width of one 2-of-7 flit as seen on the link wires.
    localparam int FLIT_W = 7;

    // Transmit FSM: IDLE has no flit outstanding, WAIT has one on the link.
    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } tx_state_t;

    // Ceiling log2, usable in constant expressions; returns at least 1.
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v = value - 1;
        while (v > 0) begin
            result = result + 1;
            v = v >> 1;
        end
        if (result == 0) begin
            result = 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/spio_sync_n.sv
// N-stage flip-flop synchroniser for signals entering from another timing
// domain; every stage resets to 0.
module spio_sync_n #(
    parameter int SIZE   = 1,
    parameter int STAGES = 2
) (
    input  logic            CLK_IN,
    input  logic            RESET_N_IN,
    input  logic [SIZE-1:0] DATA_IN,
    output logic [SIZE-1:0] DATA_OUT
);

    logic [SIZE-1:0] chain [STAGES];

    // Shift the asynchronous input through the chain of metastability flops.
    always_ff @(posedge CLK_IN or negedge RESET_N_IN) begin
        if (!RESET_N_IN) begin
            for (int i = 0; i < STAGES; i++) begin
                chain[i] <= '0;
            end
        end else begin
            chain[0] <= DATA_IN;
            for (int i = 1; i < STAGES; i++) begin
                chain[i] <= chain[i-1];
            end
        end
    end

    assign DATA_OUT = chain[STAGES-1];

endmodule

// File: rtl/spio_spinnaker_link_sync_tx_fifo.sv
// Transmit buffer feeding a SpiNNaker 2-of-7 link: queues flits from the
// serializer and releases one at a time, each after the link acknowledges
// the previous one by toggling SL_ACK_IN. Also watches for a stuck ack,
// supports discarding queued flits, and reports the queue depth.
module spio_spinnaker_link_sync_tx_fifo
    import spio_spinnaker_link_pkg::*;
#(
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT_W   = 16
) (
    input  logic                    CLK_IN,
    input  logic                    RESET_N_IN,
    input  logic [FLIT_W-1:0]       flt_data_2of7,
    input  logic                    flt_vld,
    output logic                    flt_rdy,
    input  logic                    flush_in,
    output logic [clog2(DEPTH):0]   occupancy,
    output logic                    busy,
    output logic                    timeout_err,
    output logic [FLIT_W-1:0]       SL_DATA_2OF7_OUT,
    input  logic                    SL_ACK_IN
);

    localparam int PTR_W = clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;
    localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);

    logic [FLIT_W-1:0]    buffer [DEPTH];
    tx_state_t            state;
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [TIMEOUT_W-1:0] to_cnt;
    logic [TIMEOUT_W-1:0] to_inc;
    logic                 old_ack;
    logic                 ack_s;
    logic                 acked;
    logic                 wr_en;
    logic                 send_en;
    logic [OCC_W-1:0]     occ_next;

    spio_sync_n #(
        .SIZE   (1),
        .STAGES (SYNC_STAGES)
    ) u_ack_sync (
        .CLK_IN     (CLK_IN),
        .RESET_N_IN (RESET_N_IN),
        .DATA_IN    (SL_ACK_IN),
        .DATA_OUT   (ack_s)
    );

    // Decide this cycle's write, send and the resulting queue depth.
    always_comb begin
        acked    = (ack_s != old_ack);
        wr_en    = flt_vld && flt_rdy && !flush_in;
        send_en  = !flush_in && (occupancy != '0) &&
                   ((state == IDLE) || ((state == WAIT) && acked));
        to_inc   = to_cnt + TIMEOUT_W'(1);
        occ_next = occupancy;
        if (flush_in) begin
            occ_next = '0;
        end else begin
            case ({wr_en, send_en})
                2'b10:   occ_next = occupancy + OCC_W'(1);
                2'b01:   occ_next = occupancy - OCC_W'(1);
                default: occ_next = occupancy;
            endcase
        end
    end

    // Flit storage; contents are only meaningful between the pointers.
    always_ff @(posedge CLK_IN) begin
        if (wr_en) begin
            buffer[wr_ptr] <= flt_data_2of7;
        end
    end

    // Pointers, occupancy and the registered ready flag.
    always_ff @(posedge CLK_IN or negedge RESET_N_IN) begin
        if (!RESET_N_IN) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
            flt_rdy   <= 1'b1;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (flush_in) begin
                rd_ptr <= wr_ptr;
            end else if (send_en) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            occupancy <= occ_next;
            flt_rdy   <= (occ_next < OCC_FULL);
        end
    end

    // Link FSM: put a flit on the wires, then hold it until the ack toggles.
    always_ff @(posedge CLK_IN or negedge RESET_N_IN) begin
        if (!RESET_N_IN) begin
            state            <= IDLE;
            SL_DATA_2OF7_OUT <= '0;
            old_ack          <= 1'b0;
            to_cnt           <= '0;
            timeout_err      <= 1'b0;
        end else begin
            if (send_en) begin
                SL_DATA_2OF7_OUT <= buffer[rd_ptr];
                old_ack          <= ack_s;
                to_cnt           <= '0;
                state            <= WAIT;
            end else if (state == WAIT) begin
                if (acked) begin
                    state <= IDLE;
                end else if (to_cnt != '1) begin
                    // Saturating wait counter; the flag is sticky until reset.
                    to_cnt <= to_inc;
                    if (to_inc == '1) begin
                        timeout_err <= 1'b1;
                    end
                end
            end
        end
    end

    assign busy = (state == WAIT);

endmodule
